// File: rtl/io_seq_pkg.sv
// io_seq_pkg: definitions shared by the io_pattern_sequencer files.
//   seq_mode_e - pattern mode encoding (CHASE, BOUNCE, BINARY, TOGGLE)
//   idx_width  - width of a counter/index that spans 0..n-1 (minimum 1)
package io_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BINARY = 2'd2,
    MODE_TOGGLE = 2'd3
  } seq_mode_e;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: step-rate divider for the pattern sequencer.
// Ports:
//   clk    in  system clock
//   nRst   in  asynchronous active-low reset
//   enable in  1 = count, 0 = hold the current count
//   tick   out high for the cycle in which the count sits at DIV-1 while enabled
module step_tick_gen
  import io_seq_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int STEP_HZ = 5
) (
  input  logic clk,
  input  logic nRst,
  input  logic enable,
  output logic tick
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int CW  = idx_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == LAST);

  // Pausing holds the count so that a resume completes the partial period.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/io_pattern_sequencer.sv
// io_pattern_sequencer: board-level output exerciser.
// Drives NUM_PINS header pins with a chase, bounce, binary-count or
// all-toggle pattern, advancing at STEP_HZ (or by single steps while
// paused), and cycles the active-low RGB and heartbeat LEDs once per step.
// Ports:
//   clk, nRst            clock, asynchronous active-low reset
//   enable               1 = free-run, 0 = paused
//   step_req             one step per cycle held high while paused
//   mode                 0 CHASE, 1 BOUNCE, 2 BINARY, 3 TOGGLE
//   pins                 pattern output, active-high
//   idx                  current position (0 in BINARY/TOGGLE)
//   wrap                 one-cycle pulse when a pattern period completes
//   nLED                 heartbeat, toggles every step
//   nLED_RED/GRN/BLU     active-low RGB
module io_pattern_sequencer
  import io_seq_pkg::*;
#(
  parameter int NUM_PINS = 20,
  parameter int CLK_HZ   = 12_000_000,
  parameter int STEP_HZ  = 5
) (
  input  logic                           clk,
  input  logic                           nRst,
  input  logic                           enable,
  input  logic                           step_req,
  input  logic [1:0]                     mode,
  output logic [NUM_PINS-1:0]            pins,
  output logic [idx_width(NUM_PINS)-1:0] idx,
  output logic                           wrap,
  output logic                           nLED,
  output logic                           nLED_RED,
  output logic                           nLED_GRN,
  output logic                           nLED_BLU
);

  localparam int IW = idx_width(NUM_PINS);
  localparam logic [IW-1:0] LAST_POS = IW'(NUM_PINS - 1);

  logic                tick;
  logic                step;
  seq_mode_e           mode_in;
  seq_mode_e           mode_reg;
  logic [IW-1:0]       pos_reg, pos_next;
  logic                dir_reg, dir_next;   // 1 = moving up
  logic [NUM_PINS-1:0] pins_reg, pins_next;
  logic                wrap_reg, wrap_next;
  logic [1:0]          rgb_reg, rgb_next;
  logic                nled_reg, red_reg, grn_reg, blu_reg;

  step_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .STEP_HZ(STEP_HZ)
  ) u_tick (
    .clk   (clk),
    .nRst  (nRst),
    .enable(enable),
    .tick  (tick)
  );

  // While free-running only the divider steps; step_req is ignored.
  assign step     = enable ? tick : step_req;
  assign mode_in  = seq_mode_e'(mode);
  assign rgb_next = rgb_reg + 2'd1;

  function automatic logic [NUM_PINS-1:0] one_hot(input logic [IW-1:0] p);
    return NUM_PINS'(1) << p;
  endfunction

  // Next pattern state, applied only on a step.
  always_comb begin
    pos_next  = pos_reg;
    dir_next  = dir_reg;
    pins_next = pins_reg;
    wrap_next = 1'b0;
    if (mode_in != mode_reg) begin
      // A mode change lands on the new mode's start state rather than advancing.
      pos_next  = '0;
      dir_next  = 1'b1;
      pins_next = (mode_in == MODE_CHASE || mode_in == MODE_BOUNCE) ? NUM_PINS'(1) : '0;
    end else begin
      case (mode_reg)
        MODE_CHASE: begin
          pos_next  = (pos_reg == LAST_POS) ? '0 : pos_reg + 1'b1;
          pins_next = one_hot(pos_next);
          wrap_next = (pos_next == '0);
        end
        MODE_BOUNCE: begin
          // Reverse on leaving an endpoint so each end is shown for one step.
          if (dir_reg) begin
            if (pos_reg == LAST_POS) begin
              pos_next = pos_reg - 1'b1;
              dir_next = 1'b0;
            end else begin
              pos_next = pos_reg + 1'b1;
            end
          end else begin
            if (pos_reg == '0) begin
              pos_next = pos_reg + 1'b1;
              dir_next = 1'b1;
            end else begin
              pos_next = pos_reg - 1'b1;
            end
          end
          pins_next = one_hot(pos_next);
          wrap_next = (pos_next == '0);
        end
        MODE_BINARY: begin
          pins_next = pins_reg + 1'b1;
          wrap_next = &pins_reg;
        end
        MODE_TOGGLE: begin
          pins_next = ~pins_reg;
          wrap_next = &pins_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mode_reg <= MODE_CHASE;
      pos_reg  <= '0;
      dir_reg  <= 1'b1;
      pins_reg <= NUM_PINS'(1);
      wrap_reg <= 1'b0;
      rgb_reg  <= 2'd0;
      nled_reg <= 1'b1;
      red_reg  <= 1'b1;
      grn_reg  <= 1'b1;
      blu_reg  <= 1'b1;
    end else begin
      wrap_reg <= 1'b0;
      if (step) begin
        mode_reg <= mode_in;
        pos_reg  <= pos_next;
        dir_reg  <= dir_next;
        pins_reg <= pins_next;
        wrap_reg <= wrap_next;
        rgb_reg  <= rgb_next;
        nled_reg <= ~nled_reg;
        // LED drives are decoded from the incoming colour so they stay registered.
        red_reg  <= ~(rgb_next == 2'd1);
        grn_reg  <= ~(rgb_next == 2'd2);
        blu_reg  <= ~(rgb_next == 2'd3);
      end
    end
  end

  assign pins     = pins_reg;
  assign idx      = pos_reg;
  assign wrap     = wrap_reg;
  assign nLED     = nled_reg;
  assign nLED_RED = red_reg;
  assign nLED_GRN = grn_reg;
  assign nLED_BLU = blu_reg;

endmodule
